// File: rtl/tkz_seq_pkg.sv
// Shared types and width helpers for the Skinny tweakey (TKz) sequencer.
// Optional abort path is enabled with the TKZ_SEQ_ABORT_EN macro.
package tkz_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        REVERT = 2'd2,
        DONE   = 2'd3
    } tkz_state_t;

    localparam int unsigned TKZ_ROUNDS_DEF = 56;
    localparam int unsigned TKZ_CPR_DEF    = 4;
    localparam int unsigned TKZ_REVERT_DEF = 1;

    // A counter over n values never collapses to zero bits, even for n==1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TKZ_ROUND_W  = cnt_width(TKZ_ROUNDS_DEF);
    localparam int unsigned TKZ_SLICE_W  = cnt_width(TKZ_CPR_DEF);
    localparam int unsigned TKZ_REVERT_W = cnt_width(TKZ_REVERT_DEF);

endpackage

// File: rtl/tkz_round_slice_cnt.sv
// Slice/round counters for the TKz sequencer: the slice index wraps every CPR
// enabled cycles and carries into the round index, which wraps after ROUNDS.
module tkz_round_slice_cnt
    import tkz_seq_pkg::*;
#(
    parameter  int unsigned ROUNDS = TKZ_ROUNDS_DEF,
    parameter  int unsigned CPR    = TKZ_CPR_DEF,
    localparam int unsigned RW     = cnt_width(ROUNDS),
    localparam int unsigned SW     = cnt_width(CPR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [RW-1:0] round,
    output logic [SW-1:0] slice,
    output logic          round_last,
    output logic          block_last
);

    logic slice_last;

    assign slice_last = (slice == SW'(CPR - 1));
    assign round_last = (round == RW'(ROUNDS - 1));
    assign block_last = slice_last & round_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            round <= '0;
            slice <= '0;
        end else if (en) begin
            if (slice_last) begin
                slice <= '0;
                round <= round_last ? '0 : round + 1'b1;
            end else begin
                slice <= slice + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tkz_seq_ctrl.sv
// Tweakey update sequencer: ROUNDS*CPR update cycles then REVERT_CYCLES restore
// cycles per block. Define TKZ_SEQ_ABORT_EN to add the abort/aborted ports.
module tkz_seq_ctrl
    import tkz_seq_pkg::*;
#(
    parameter  int unsigned ROUNDS        = TKZ_ROUNDS_DEF,
    parameter  int unsigned CPR           = TKZ_CPR_DEF,
    parameter  int unsigned REVERT_CYCLES = TKZ_REVERT_DEF,
    localparam int unsigned RW            = cnt_width(ROUNDS),
    localparam int unsigned SW            = cnt_width(CPR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
`ifdef TKZ_SEQ_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          ready,
    output logic          busy,
    output logic          enc,
    output logic          se,
    output logic [RW-1:0] round,
    output logic [SW-1:0] slice,
    output logic          last_round,
    output logic          done
);

    localparam int unsigned     VW       = cnt_width(REVERT_CYCLES);
    localparam logic [VW-1:0]   REV_LOAD = VW'((REVERT_CYCLES > 0) ? REVERT_CYCLES - 1 : 0);
    // With no revert cycles the last round (or an abort) goes straight to DONE.
    localparam tkz_state_t      POST_RND = (REVERT_CYCLES > 0) ? REVERT : DONE;

    tkz_state_t    state, state_nxt;
    logic [VW-1:0] rev_cnt, rev_cnt_nxt;
    logic          cnt_en, cnt_clear;
    logic          round_last, block_last;
    logic          abort_take;

`ifdef TKZ_SEQ_ABORT_EN
    logic aborted_q, aborted_nxt;

    assign abort_take = (state == ROUND) & abort;
    assign aborted    = aborted_q;

    always_comb begin
        aborted_nxt = aborted_q;
        if (abort_take)
            aborted_nxt = 1'b1;
        if (state == DONE)
            aborted_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            aborted_q <= 1'b0;
        else
            aborted_q <= aborted_nxt;
    end
`else
    assign abort_take = 1'b0;
`endif

    tkz_round_slice_cnt #(
        .ROUNDS (ROUNDS),
        .CPR    (CPR)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .en         (cnt_en),
        .round      (round),
        .slice      (slice),
        .round_last (round_last),
        .block_last (block_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rev_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rev_cnt <= rev_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rev_cnt_nxt = rev_cnt;
        cnt_en      = 1'b0;
        cnt_clear   = (state != ROUND);
        ready       = 1'b0;
        busy        = 1'b0;
        enc         = 1'b0;
        se          = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start)
                    state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                enc  = ~hold;
                if (abort_take) begin
                    state_nxt   = POST_RND;
                    rev_cnt_nxt = REV_LOAD;
                    cnt_clear   = 1'b1;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    if (block_last) begin
                        state_nxt   = POST_RND;
                        rev_cnt_nxt = REV_LOAD;
                    end
                end
            end
            REVERT: begin
                busy = 1'b1;
                enc  = ~hold;
                se   = 1'b1;
                if (!hold) begin
                    if (rev_cnt == '0)
                        state_nxt = DONE;
                    else
                        rev_cnt_nxt = rev_cnt - 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_round = (state == ROUND) & round_last;

endmodule

// File: tb/tb_tkz_seq_ctrl.sv
// Self-checking bench for tkz_seq_ctrl: a reset/start vector table, directed
// block sequences, and random stimulus checked against a progress-count model.
module tb_tkz_seq_ctrl;

    localparam int ROUNDS = 56;
    localparam int CPR    = 4;
    localparam int REV    = 1;
    localparam int TOTAL  = ROUNDS * CPR;

    logic       clk = 1'b0;
    logic       rst, start, hold, abortReq;
    logic       ready, busy, enc, se, last_round, done;
    logic [5:0] round;
    logic [1:0] slice;
`ifdef TKZ_SEQ_ABORT_EN
    logic       aborted;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 running, 2 done; mP counts non-held
    // cycles consumed in the current block.
    int mMode = 0;
    int mP    = 0;
    bit mAborted = 1'b0;

    typedef struct {
        bit start, hold, rst;
        bit ready, busy, enc, se, done;
        int round, slice;
    } vec_t;

    vec_t vecs[10];

    tkz_seq_ctrl #(
        .ROUNDS        (ROUNDS),
        .CPR           (CPR),
        .REVERT_CYCLES (REV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
`ifdef TKZ_SEQ_ABORT_EN
        .abort      (abortReq),
        .aborted    (aborted),
`endif
        .ready      (ready),
        .busy       (busy),
        .enc        (enc),
        .se         (se),
        .round      (round),
        .slice      (slice),
        .last_round (last_round),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit h, input bit r, input bit a);
        @(negedge clk);
        start    = s;
        hold     = h;
        rst      = r;
        abortReq = a;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        bit inRound;
        int eRound, eSlice;
        inRound = (mMode == 1) && (mP < TOTAL);
        eRound  = inRound ? mP / CPR : 0;
        eSlice  = inRound ? mP % CPR : 0;
        checkField({tag, " ready"}, 32'(ready), 32'(mMode == 0));
        checkField({tag, " busy"},  32'(busy),  32'(mMode == 1));
        checkField({tag, " enc"},   32'(enc),   32'((mMode == 1) && !hold));
        checkField({tag, " se"},    32'(se),    32'((mMode == 1) && !inRound));
        checkField({tag, " done"},  32'(done),  32'(mMode == 2));
        checkField({tag, " round"}, 32'(round), 32'(eRound));
        checkField({tag, " slice"}, 32'(slice), 32'(eSlice));
        checkField({tag, " last_round"}, 32'(last_round), 32'(inRound && (eRound == ROUNDS - 1)));
`ifdef TKZ_SEQ_ABORT_EN
        checkField({tag, " aborted"}, 32'(aborted), 32'(mAborted && (mMode != 0)));
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mMode = 0; mP = 0; mAborted = 1'b0;
        end else begin
            case (mMode)
                0: if (start) begin mMode = 1; mP = 0; end
                1: begin
`ifdef TKZ_SEQ_ABORT_EN
                    if (abortReq && mP < TOTAL) begin
                        mP = TOTAL; mAborted = 1'b1;
                    end else
`endif
                    if (!hold) mP++;
                    if (mP >= TOTAL + REV) mMode = 2;
                end
                default: begin mMode = 0; mAborted = 1'b0; end
            endcase
        end
    endtask

    task automatic step(input bit s, input bit h, input bit r, input bit a, input string tag);
        applyStimulus(s, h, r, a);
        checkOutput(tag);
        advance();
    endtask

    // Start a block at cycle 0 and run 300 further cycles with optional hold
    // window and optional start re-pulses at cycles 50, 226 and 227.
    task automatic fullBlock(input int holdStart, input int holdLen, input bit repulse,
                             input int expDone, input string name);
        int doneAt, nDone;
        bit s, h;
        doneAt = -1;
        nDone  = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, {name, " start"});
        for (int c = 1; c <= 300; c++) begin
            h = (c >= holdStart) && (c < holdStart + holdLen);
            s = repulse && (c == 50 || c == 226 || c == 227);
            applyStimulus(s, h, 1'b0, 1'b0);
            checkOutput(name);
            if (h) begin
                checkField({name, " held round"}, 32'(round), 32'd10);
                checkField({name, " held slice"}, 32'(slice), 32'd2);
            end
            if (done === 1'b1) begin
                nDone++;
                if (doneAt < 0) doneAt = c;
            end
            if (c == expDone + 1)
                checkField({name, " ready after done"}, 32'(ready), 32'd1);
            advance();
        end
        checkField({name, " done cycle"}, doneAt, expDone);
        checkField({name, " done count"}, nDone, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, {name, " cleanup"});
    endtask

    initial begin
        int nDone;
        rst = 1'b1; start = 1'b0; hold = 1'b0; abortReq = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        advance();

        // start,hold,rst -> ready,busy,enc,se,done,round,slice
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].hold, vecs[i].rst, 1'b0);
            checkField($sformatf("vec%0d ready", i), 32'(ready), 32'(vecs[i].ready));
            checkField($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].busy));
            checkField($sformatf("vec%0d enc", i),   32'(enc),   32'(vecs[i].enc));
            checkField($sformatf("vec%0d se", i),    32'(se),    32'(vecs[i].se));
            checkField($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].done));
            checkField($sformatf("vec%0d round", i), 32'(round), 32'(vecs[i].round));
            checkField($sformatf("vec%0d slice", i), 32'(slice), 32'(vecs[i].slice));
            advance();
        end

        fullBlock(0, 0, 1'b0, 226, "plain");
        fullBlock(43, 5, 1'b0, 231, "hold");
        fullBlock(0, 0, 1'b1, 226, "repulse");

        // Reset in the middle of round 30 must drop the block without a done.
        step(1'b1, 1'b0, 1'b0, 1'b0, "midrst start");
        for (int c = 1; c <= 121; c++)
            step(1'b0, 1'b0, (c == 121), 1'b0, "midrst run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkField("midrst ready", 32'(ready), 32'd1);
        checkField("midrst enc", 32'(enc), 32'd0);
        advance();
        nDone = 0;
        for (int c = 0; c < 250; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("midrst idle");
            if (done === 1'b1) nDone++;
            advance();
        end
        checkField("midrst no done", nDone, 0);

`ifdef TKZ_SEQ_ABORT_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, "abort start");
        for (int c = 1; c <= 85; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, (c == 82));
            checkOutput("abort");
            if (c == 83) checkField("abort se", 32'(se), 32'd1);
            if (c == 84) begin
                checkField("abort done", 32'(done), 32'd1);
                checkField("abort aborted", 32'(aborted), 32'd1);
            end
            advance();
        end
`endif

        for (int c = 0; c < 8000; c++) begin
            bit a;
            a = 1'b0;
`ifdef TKZ_SEQ_ABORT_EN
            a = ($urandom_range(0, 299) == 0);
`endif
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 999) == 0), a, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
